// File: rtl/axi_iw_remap_table.sv
// ID remap table for AXI ID-width reduction.
// Allocates narrow master IDs per wide slave ID and counts outstanding txns.
`timescale 1ns/1ps
module axi_iw_remap_table #(
  parameter int SlvIdWidth   = 8,
  parameter int MstIdWidth   = 2,
  parameter int MaxUniqIds   = 4,
  parameter int MaxTxnsPerId = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  input  logic [SlvIdWidth-1:0] req_slv_id_i,
  output logic                  req_ready_o,
  output logic [MstIdWidth-1:0] req_mst_id_o,
  input  logic                  rsp_valid_i,
  input  logic                  rsp_ready_i,
  input  logic                  rsp_last_i,
  input  logic [MstIdWidth-1:0] rsp_mst_id_i,
  output logic [SlvIdWidth-1:0] rsp_slv_id_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int CntW = $clog2(MaxTxnsPerId + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTxnsPerId);

  logic [MaxUniqIds-1:0] vld_q;
  logic [SlvIdWidth-1:0] slv_id_q [MaxUniqIds];
  logic [CntW-1:0]       cnt_q    [MaxUniqIds];

  logic                  hit;
  logic [MstIdWidth-1:0] hit_idx;
  logic [CntW-1:0]       hit_cnt;
  logic                  free;
  logic [MstIdWidth-1:0] free_idx;

  logic                  rsp_vld;
  logic [CntW-1:0]       rsp_cnt;
  logic [SlvIdWidth-1:0] rsp_slv;

  logic                  push;
  logic                  pop;
  logic                  pop_legal;
  logic [MaxUniqIds-1:0] push_sel;
  logic [MaxUniqIds-1:0] pop_sel;

  // Scan high to low so the lowest matching index wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_cnt  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = MaxUniqIds - 1; i >= 0; i--) begin
      if (!vld_q[i]) begin
        free     = 1'b1;
        free_idx = MstIdWidth'(i);
      end
      if (vld_q[i] && slv_id_q[i] == req_slv_id_i) begin
        hit     = 1'b1;
        hit_idx = MstIdWidth'(i);
        hit_cnt = cnt_q[i];
      end
    end
  end

  // Out-of-range master IDs read as an empty entry.
  always_comb begin
    rsp_vld = 1'b0;
    rsp_cnt = '0;
    rsp_slv = '0;
    for (int i = 0; i < MaxUniqIds; i++) begin
      if (rsp_mst_id_i == MstIdWidth'(i)) begin
        rsp_vld = vld_q[i];
        rsp_cnt = cnt_q[i];
        rsp_slv = slv_id_q[i];
      end
    end
  end

  assign req_ready_o  = hit ? (hit_cnt < MaxCnt) : free;
  assign req_mst_id_o = hit ? hit_idx : free_idx;
  assign rsp_slv_id_o = rsp_slv;
  assign full_o       = &vld_q;
  assign empty_o      = ~|vld_q;

  assign push      = req_valid_i && req_ready_o;
  assign pop       = rsp_valid_i && rsp_ready_i && rsp_last_i;
  assign pop_legal = rsp_vld && (rsp_cnt != '0);

  always_comb begin
    push_sel = '0;
    pop_sel  = '0;
    for (int i = 0; i < MaxUniqIds; i++) begin
      push_sel[i] = push && (req_mst_id_o == MstIdWidth'(i));
      pop_sel[i]  = pop && pop_legal &&
                    (rsp_mst_id_i == MstIdWidth'(i));
    end
  end

  // Push and pop on the same entry cancel out; entry stays allocated.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < MaxUniqIds; i++) begin
        slv_id_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < MaxUniqIds; i++) begin
        if (push_sel[i] && !pop_sel[i]) begin
          if (vld_q[i]) begin
            cnt_q[i] <= cnt_q[i] + CntW'(1);
          end else begin
            vld_q[i]    <= 1'b1;
            slv_id_q[i] <= req_slv_id_i;
            cnt_q[i]    <= CntW'(1);
          end
        end else if (pop_sel[i] && !push_sel[i]) begin
          cnt_q[i] <= cnt_q[i] - CntW'(1);
          if (cnt_q[i] == CntW'(1)) begin
            vld_q[i] <= 1'b0;
          end
        end
      end
    end
  end

  a_pop_legal : assert property (
    @(posedge clk_i) disable iff (rst_i)
    pop |-> pop_legal
  );

  a_req_stable : assert property (
    @(posedge clk_i) disable iff (rst_i)
    (req_valid_i && !req_ready_o) |=>
      (req_valid_i && $stable(req_slv_id_i))
  );

endmodule

// File: tb/tb_axi_iw_remap_table.sv
// Directed vector bench for axi_iw_remap_table.
// One table row per clock cycle, plus an async reset sequence.
`timescale 1ns/1ps
module tb_axi_iw_remap_table;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       req_valid_i;
  logic [7:0] req_slv_id_i;
  logic       req_ready_o;
  logic [1:0] req_mst_id_o;
  logic       rsp_valid_i;
  logic       rsp_ready_i;
  logic       rsp_last_i;
  logic [1:0] rsp_mst_id_i;
  logic [7:0] rsp_slv_id_o;
  logic       full_o;
  logic       empty_o;

  int errs   = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  axi_iw_remap_table #(
    .SlvIdWidth  (8),
    .MstIdWidth  (2),
    .MaxUniqIds  (4),
    .MaxTxnsPerId(4)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_slv_id_i(req_slv_id_i),
    .req_ready_o (req_ready_o),
    .req_mst_id_o(req_mst_id_o),
    .rsp_valid_i (rsp_valid_i),
    .rsp_ready_i (rsp_ready_i),
    .rsp_last_i  (rsp_last_i),
    .rsp_mst_id_i(rsp_mst_id_i),
    .rsp_slv_id_o(rsp_slv_id_o),
    .full_o      (full_o),
    .empty_o     (empty_o)
  );

  typedef struct {
    logic       rv;
    logic [7:0] rid;
    logic       pv;
    logic       pr;
    logic       pl;
    logic [1:0] pm;
    logic       er;
    logic [1:0] em;
    logic [7:0] es;
    logic       ef;
    logic       ee;
  } vec_t;

  localparam int NVec = 34;
  vec_t tbl [NVec];

  function automatic vec_t mk(
    input logic rv, input logic [7:0] rid,
    input logic pv, input logic pr, input logic pl,
    input logic [1:0] pm,
    input logic er, input logic [1:0] em,
    input logic [7:0] es, input logic ef, input logic ee
  );
    vec_t v;
    v.rv = rv; v.rid = rid;
    v.pv = pv; v.pr = pr; v.pl = pl; v.pm = pm;
    v.er = er; v.em = em; v.es = es;
    v.ef = ef; v.ee = ee;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input vec_t v);
    chk({tag, " ready"}, 32'(req_ready_o), 32'(v.er));
    if (v.er)
      chk({tag, " mst_id"}, 32'(req_mst_id_o), 32'(v.em));
    chk({tag, " rsp_slv"}, 32'(rsp_slv_id_o), 32'(v.es));
    chk({tag, " full"}, 32'(full_o), 32'(v.ef));
    chk({tag, " empty"}, 32'(empty_o), 32'(v.ee));
  endtask

  task automatic drive(input vec_t v);
    req_valid_i  = v.rv;
    req_slv_id_i = v.rid;
    rsp_valid_i  = v.pv;
    rsp_ready_i  = v.pr;
    rsp_last_i   = v.pl;
    rsp_mst_id_i = v.pm;
  endtask

  initial begin
    vec_t idle;
    // rv rid  pv pr pl pm  er em es  ef ee
    tbl[0]  = mk(0,8'h00, 0,0,0,0, 1,0,8'h00, 0,1);
    tbl[1]  = mk(1,8'h5A, 0,0,0,0, 1,0,8'h00, 0,1);
    tbl[2]  = mk(1,8'h5A, 0,0,0,0, 1,0,8'h5A, 0,0);
    tbl[3]  = mk(1,8'h5A, 0,0,0,0, 1,0,8'h5A, 0,0);
    tbl[4]  = mk(1,8'h5A, 0,0,0,0, 1,0,8'h5A, 0,0);
    tbl[5]  = mk(1,8'h5A, 0,0,0,0, 0,0,8'h5A, 0,0);
    tbl[6]  = mk(1,8'h5A, 1,1,1,0, 0,0,8'h5A, 0,0);
    tbl[7]  = mk(1,8'h5A, 0,0,0,0, 1,0,8'h5A, 0,0);
    tbl[8]  = mk(0,8'h00, 1,1,1,0, 1,1,8'h5A, 0,0);
    tbl[9]  = mk(0,8'h00, 1,1,1,0, 1,1,8'h5A, 0,0);
    tbl[10] = mk(0,8'h00, 1,1,1,0, 1,1,8'h5A, 0,0);
    tbl[11] = mk(0,8'h00, 1,1,1,0, 1,1,8'h5A, 0,0);
    tbl[12] = mk(0,8'h00, 0,0,0,0, 1,0,8'h5A, 0,1);
    tbl[13] = mk(1,8'h77, 0,0,0,0, 1,0,8'h5A, 0,1);
    tbl[14] = mk(0,8'h00, 1,1,0,0, 1,1,8'h77, 0,0);
    tbl[15] = mk(0,8'h00, 1,1,0,0, 1,1,8'h77, 0,0);
    tbl[16] = mk(0,8'h00, 1,0,1,0, 1,1,8'h77, 0,0);
    tbl[17] = mk(0,8'h00, 0,0,0,0, 1,1,8'h77, 0,0);
    tbl[18] = mk(0,8'h00, 1,1,1,0, 1,1,8'h77, 0,0);
    tbl[19] = mk(0,8'h00, 0,0,0,0, 1,0,8'h77, 0,1);
    tbl[20] = mk(1,8'h10, 0,0,0,0, 1,0,8'h77, 0,1);
    tbl[21] = mk(1,8'h20, 0,0,0,0, 1,1,8'h10, 0,0);
    tbl[22] = mk(1,8'h30, 0,0,0,0, 1,2,8'h10, 0,0);
    tbl[23] = mk(1,8'h40, 0,0,0,0, 1,3,8'h10, 0,0);
    tbl[24] = mk(1,8'h50, 0,0,0,0, 0,0,8'h10, 1,0);
    tbl[25] = mk(1,8'h50, 1,1,1,2, 0,0,8'h30, 1,0);
    tbl[26] = mk(1,8'h50, 0,0,0,2, 1,2,8'h30, 0,0);
    tbl[27] = mk(0,8'h00, 0,0,0,2, 0,0,8'h50, 1,0);
    tbl[28] = mk(1,8'h20, 1,1,1,1, 1,1,8'h20, 1,0);
    tbl[29] = mk(0,8'h00, 0,0,0,1, 0,0,8'h20, 1,0);
    tbl[30] = mk(0,8'h00, 1,1,1,1, 0,0,8'h20, 1,0);
    tbl[31] = mk(1,8'h99, 0,0,0,1, 1,1,8'h20, 0,0);
    tbl[32] = mk(0,8'h00, 1,1,1,3, 0,0,8'h40, 1,0);
    tbl[33] = mk(0,8'h00, 0,0,0,1, 1,3,8'h99, 0,0);

    idle = mk(0,8'h00, 0,0,0,0, 1,0,8'h00, 0,1);
    rst_i = 1'b1;
    drive(idle);
    #1;
    chk_outs("reset", idle);
    @(negedge clk_i);
    chk_outs("reset hold", idle);
    rst_i = 1'b0;

    for (int k = 0; k < NVec; k++) begin
      if (k != 0) @(negedge clk_i);
      drive(tbl[k]);
      #1;
      chk_outs($sformatf("vec%0d", k), tbl[k]);
    end

    // Async reset mid-cycle with three entries live.
    @(negedge clk_i);
    drive(mk(0,8'h00, 0,0,0,1, 1,3,8'h99, 0,0));
    #2;
    rst_i = 1'b1;
    #1;
    chk_outs("async rst", mk(0,8'h00, 0,0,0,1, 1,0,8'h00, 0,1));
    @(negedge clk_i);
    rst_i = 1'b0;
    drive(mk(1,8'hAB, 0,0,0,0, 1,0,8'h00, 0,1));
    #1;
    chk_outs("post rst grant",
             mk(1,8'hAB, 0,0,0,0, 1,0,8'h00, 0,1));
    @(negedge clk_i);
    drive(mk(0,8'h00, 0,0,0,0, 1,1,8'hAB, 0,0));
    #1;
    chk_outs("post rst alloc",
             mk(0,8'h00, 0,0,0,0, 1,1,8'hAB, 0,0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/axi_iw_remap_table.md
# axi_iw_remap_table

Allocation and bookkeeping controller for AXI ID-width reduction: maps each wide slave-port ID onto one of `MaxUniqIds` narrow master-port IDs and counts outstanding transactions per mapping. Frees the mapping when its last response returns. One instance sequences the AW/B direction and one the AR/R direction of an ID-width converter datapath, sitting between the slave-port address channel and the master-port ID field.

## Interface
- `SlvIdWidth`, 8: slave-port ID width.
- `MstIdWidth`, 2: master-port ID width; `MaxUniqIds <= 2**MstIdWidth`.
- `MaxUniqIds`, 4: table entries, i.e. concurrently active slave IDs.
- `MaxTxnsPerId`, 4: outstanding transactions per entry, >= 1.
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `req_valid_i`  in  1  address beat with a slave ID wants a master ID.
- `req_slv_id_i`  in  SlvIdWidth  slave ID of that beat.
- `req_ready_o`  out  1  a master ID is grantable this cycle.
- `req_mst_id_o`  out  MstIdWidth  granted master ID; valid while `req_ready_o`.
- `rsp_valid_i`  in  1  response beat on master port.
- `rsp_ready_i`  in  1  response beat accepted downstream.
- `rsp_last_i`  in  1  final beat of the transaction (tie 1 for B).
- `rsp_mst_id_i`  in  MstIdWidth  master ID of the response.
- `rsp_slv_id_o`  out  SlvIdWidth  slave ID restored for `rsp_mst_id_i`.
- `full_o`  out  1  all entries valid.
- `empty_o`  out  1  no entry valid.

## Operation
- Per entry `i`: `vld[i]`, `slv_id[i]`, `cnt[i]` (width `$clog2(MaxTxnsPerId+1)`). Entry index is the master ID.
- Hit: some `vld[i]` with `slv_id[i]==req_slv_id_i`; at most one hit exists by construction.
- Grant rules (combinational, independent of `req_valid_i` and all `rsp_*`):
  - hit and `cnt[i] < MaxTxnsPerId` -> ready, `req_mst_id_o = i`;
  - hit and `cnt[i] == MaxTxnsPerId` -> not ready (preserves per-ID ordering; never allocate a second entry for the same slave ID);
  - no hit, some entry invalid -> ready, `req_mst_id_o` = lowest-index invalid entry;
  - no hit, table full -> not ready.
- Push (`req_valid_i && req_ready_o`): hit -> `cnt+1`; allocation -> `vld=1`, `slv_id` stored, `cnt=1`.
- Pop (`rsp_valid_i && rsp_ready_i && rsp_last_i`): `cnt[rsp_mst_id_i]-1`; reaching 0 clears `vld`.
- `rsp_slv_id_o = slv_id[rsp_mst_id_i]` always, including non-last beats.
- Simultaneous push and pop on the same entry: `cnt` unchanged, `vld` stays 1 even if `cnt` was 1.
- Pop frees an entry in the same cycle a no-hit request sees a full table: stall this cycle, grant next cycle (no bypass).
- Pop to an entry with `cnt==0` or `vld==0`: protocol error; state unchanged; simulation assertion fires.
- `req_slv_id_i` must remain stable while `req_valid_i` is high and not granted (AXI stability); assertion checks.

## Timing
- Reset: all `vld=0`, `cnt=0`, `slv_id=0`. Outputs in and right after reset: `req_ready_o=1`, `req_mst_id_o=0`, `rsp_slv_id_o=0`, `full_o=0`, `empty_o=1`.
- Reset asserted mid-operation: the table clears immediately. Outstanding transactions are forgotten, and the surrounding datapath is reset with it.
- Grant latency 0 cycles: ready and ID settle combinationally from registered state and `req_slv_id_i`; table update visible the next cycle.
- No combinational path from `rsp_*` to `req_*` or from `req_valid_i` to `req_ready_o`.
- `full_o`/`empty_o` are derived from registered `vld` only.

## Test plan
- After reset, request slave ID 0x5A -> `req_ready_o=1`, `req_mst_id_o=0`; next cycle `empty_o=0`, entry 0 `cnt=1`.
- Push ID 0x5A four times (`MaxTxnsPerId=4`), then a fifth request -> `req_ready_o=0`. Pop one last-beat on master ID 0 -> ready the following cycle with master ID 0.
- Push IDs 0x10, 0x20, 0x30, 0x40 -> master IDs 0..3 and `full_o=1`. Request 0x50 -> stalled. Pop master ID 2 (cnt 1) -> 0x50 is granted master ID 2 one cycle later.
- Entry 1 at `cnt=1`: push its slave ID and pop master ID 1 in the same cycle -> `cnt` stays 1, `vld` stays 1, `rsp_slv_id_o` returns the stored ID.
- Read burst len 3 on master ID 0: non-last beats leave `cnt` unchanged. The last beat with `rsp_ready_i=0` leaves `cnt` unchanged; with `rsp_ready_i=1` it decrements.
- Assert `rst_i` asynchronously with 3 entries valid -> immediately `empty_o=1`, `full_o=0`, `req_ready_o=1`; first grant after release is master ID 0.
